// File: rtl/prefetch_queue_x_if.sv
// Memory-side burst bus of prefetch_queue_x: address beats out, tagged data beats back.
interface prefetch_queue_x_if #(
   parameter int AW = 36
);
   logic        ACT;
   logic        NEXT;
   logic [AW:0] OFFSET;
   logic [2:0]  TAGo;
   logic        DRDY;
   logic [7:0]  TAGi;
   logic [63:0] DTi;

   modport master (output ACT, OFFSET, TAGo, input NEXT, DRDY, TAGi, DTi);
   modport slave  (input ACT, OFFSET, TAGo, output NEXT, DRDY, TAGi, DTi);
endinterface

// File: rtl/prefetch_queue_x.sv
// Instruction prefetcher: line bursts into a DEPTH-word ring queue feeding the sequencer.
// Optional PF_FAULT_HALT_EN: stop requesting new lines after a fault beat until JUMP.
module prefetch_queue_x #(
   parameter int AW         = 36,
   parameter int DEPTH      = 16,
   parameter int LINE_WORDS = 8,
   parameter int TMO_BITS   = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               JUMP,
   input  logic [AW-1:0]      JADDR,
   input  logic               STOP,
   prefetch_queue_x_if.master bus,
   output logic               IRDY,
   input  logic               IFETCH,
   output logic [63:0]        IBUS,
   output logic [3:0]         VF,
   output logic               IERR,
   output logic [AW-1:0]      IIP,
   output logic               FATAL
);
   localparam int QW  = $clog2(DEPTH);
   localparam int QP  = QW + 1;
   localparam int LB  = $clog2(LINE_WORDS);
   localparam int CW  = LB + 1;
   localparam int LAW = AW - 2 - LB;
   localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);
   localparam logic [QP-1:0] START_MAX = QP'(DEPTH - LINE_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]       bcnt, rcnt, outs, outs_jump;
   logic [LB-1:0]       skip;
   logic [LAW-1:0]      fptr;
   logic [QP-1:0]       head, tail, count;
   logic [AW-1:0]       hip;
   logic [TMO_BITS-1:0] tmo;
   logic [63:0]         qdata [DEPTH];
   logic                qflt  [DEPTH];
   logic                code_beat, in_line, line_beat, keep, line_done;
   logic                issue, pop, start_ok, halt;

   assign code_beat = bus.DRDY && (bus.TAGi[7:5] == 3'b011) && !bus.TAGi[3];
   assign in_line   = (state == S_REQ) || (state == S_WAIT);
   assign line_beat = in_line && code_beat;
   assign line_done = line_beat && (rcnt == LAST_BEAT) && !JUMP;
   assign keep      = line_beat && (skip == '0) && !JUMP;
   assign count     = tail - head;
   assign pop       = IFETCH && IRDY && !JUMP;
   // Space is checked only when leaving IDLE; the whole line is thereby reserved.
   assign start_ok  = !STOP && !halt && (count <= START_MAX);

   assign bus.ACT    = (state == S_REQ) && !JUMP;
   assign issue      = bus.ACT && bus.NEXT;
   assign bus.OFFSET = {fptr, bcnt[LB-1:0], 3'b000};
   assign bus.TAGo   = {bus.ACT && (bcnt == LAST_BEAT), 2'b00};

   assign IRDY = (count != '0);
   assign IBUS = qdata[head[QW-1:0]];
   assign IERR = IRDY && qflt[head[QW-1:0]];
   assign VF   = IRDY ? (4'b1111 << hip[1:0]) : 4'b0000;
   assign IIP  = {hip[AW-1:2], 2'b00};

`ifdef PF_FAULT_HALT_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                    halt <= 1'b0;
      else if (JUMP)                 halt <= 1'b0;
      else if (keep && bus.TAGi[4])  halt <= 1'b1;
   end
`else
   assign halt = 1'b0;
`endif

   // Beats still owed by memory if the current line is abandoned this cycle.
   always_comb begin
      outs_jump = '0;
      case (state)
         S_REQ, S_WAIT: outs_jump = bcnt - rcnt - CW'(code_beat);
         S_DRAIN:       outs_jump = outs - CW'(code_beat);
         default:       outs_jump = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (JUMP) begin
         state_nxt = (outs_jump != '0) ? S_DRAIN : S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start_ok) state_nxt = S_REQ;
            S_REQ:   if (issue && (bcnt == LAST_BEAT)) state_nxt = line_done ? S_IDLE : S_WAIT;
            S_WAIT:  if (line_done) state_nxt = S_IDLE;
            S_DRAIN: if (code_beat && (outs == CW'(1))) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= S_IDLE;
         bcnt  <= '0;
         rcnt  <= '0;
         outs  <= '0;
         skip  <= '0;
         fptr  <= '0;
         head  <= '0;
         tail  <= '0;
         hip   <= '0;
         tmo   <= '0;
         FATAL <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == S_IDLE) bcnt <= '0;
         else if (issue)      bcnt <= bcnt + 1'b1;

         if (state == S_IDLE) rcnt <= '0;
         else if (line_beat)  rcnt <= rcnt + 1'b1;

         if (JUMP)                                outs <= outs_jump;
         else if ((state == S_DRAIN) && code_beat) outs <= outs - 1'b1;

         if (JUMP)                             skip <= JADDR[2 +: LB];
         else if (line_beat && (skip != '0))   skip <= skip - 1'b1;

         if (JUMP)           fptr <= JADDR[AW-1 -: LAW];
         else if (line_done) fptr <= fptr + 1'b1;

         if (JUMP) begin
            head <= '0;
            tail <= '0;
            hip  <= JADDR;
         end else begin
            if (keep) tail <= tail + 1'b1;
            if (pop) begin
               head <= head + 1'b1;
               hip  <= {hip[AW-1:2] + 1'b1, 2'b00};
            end
         end

         if (JUMP || bus.DRDY || !((state == S_WAIT) || (state == S_DRAIN))) tmo <= '0;
         else if (tmo != '1) tmo <= tmo + 1'b1;

         FATAL <= FATAL | (tmo == '1);
      end
   end

   always_ff @(posedge CLK) begin
      if (keep) begin
         qdata[tail[QW-1:0]] <= bus.DTi;
         qflt[tail[QW-1:0]]  <= bus.TAGi[4];
      end
   end
endmodule

// File: tb/tb_prefetch_queue_x.sv
// Directed self-checking bench for prefetch_queue_x (DEPTH=16, LINE_WORDS=8, TMO_BITS=8).
module tb_prefetch_queue_x;
   localparam int AW = 36;

   logic          CLK = 1'b0;
   logic          RESET, JUMP, STOP, IFETCH;
   logic [AW-1:0] JADDR;
   logic          IRDY, IERR, FATAL;
   logic [63:0]   IBUS;
   logic [3:0]    VF;
   logic [AW-1:0] IIP;
   int            n_checks = 0;
   int            n_errs   = 0;

   prefetch_queue_x_if #(.AW(AW)) bus ();

   prefetch_queue_x #(.AW(AW), .DEPTH(16), .LINE_WORDS(8), .TMO_BITS(8)) dut (
      .CLK(CLK), .RESET(RESET), .JUMP(JUMP), .JADDR(JADDR), .STOP(STOP),
      .bus(bus), .IRDY(IRDY), .IFETCH(IFETCH), .IBUS(IBUS), .VF(VF),
      .IERR(IERR), .IIP(IIP), .FATAL(FATAL)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic beat(input logic [63:0] d, input logic [7:0] tg);
      bus.DRDY = 1'b1;
      bus.TAGi = tg;
      bus.DTi  = d;
      tick();
      bus.DRDY = 1'b0;
      bus.TAGi = 8'h00;
   endtask

   task automatic jump(input logic [AW-1:0] a);
      JUMP  = 1'b1;
      JADDR = a;
      tick();
      JUMP  = 1'b0;
   endtask

   task automatic wait_act(input int budget, output int n);
      n = 0;
      while (!bus.ACT && n < budget) begin
         tick();
         n++;
      end
      chk("act_seen", bus.ACT, 1);
   endtask

   task automatic wait_drop(input int budget);
      int n = 0;
      while (bus.ACT && n < budget) begin
         tick();
         n++;
      end
      chk("act_drop", bus.ACT, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [63:0] dl, el, l1, l2, nl, pl;
      dl = 64'hD0D0_0000_0000_0000;
      el = 64'hE0E0_0000_0000_0000;
      l1 = 64'hA1A1_0000_0000_0000;
      l2 = 64'hA2A2_0000_0000_0000;
      nl = 64'hB0B0_0000_0000_0000;
      pl = 64'hC0C0_0000_0000_0000;

      RESET = 1'b0; JUMP = 1'b0; STOP = 1'b1; IFETCH = 1'b0; JADDR = '0;
      bus.NEXT = 1'b1; bus.DRDY = 1'b0; bus.TAGi = 8'h00; bus.DTi = '0;
      tick(); tick();
      chk("rst_act",   bus.ACT,  0);
      chk("rst_tago",  bus.TAGo, 0);
      chk("rst_irdy",  IRDY,     0);
      chk("rst_vf",    VF,       0);
      chk("rst_ierr",  IERR,     0);
      chk("rst_fatal", FATAL,    0);
      RESET = 1'b1;
      tick();

      // 1: aligned line at 0x40
      STOP = 1'b0;
      jump(36'h40);
      wait_act(5, n);
      chk("t1_act_lat", n, 1);
      STOP = 1'b1;
      for (int b = 0; b < 8; b++) begin
         chk("t1_act",    bus.ACT,    1);
         chk("t1_offset", bus.OFFSET, 64'h80 + 64'(8 * b));
         chk("t1_tago",   bus.TAGo,   (b == 7) ? 64'd4 : 64'd0);
         tick();
      end
      chk("t1_act_end", bus.ACT, 0);
      chk("t1_irdy_pre", IRDY, 0);
      beat(dl + 64'd0, 8'h60);
      chk("t1_irdy", IRDY, 1);
      chk("t1_ibus", IBUS, dl);
      chk("t1_vf",   VF,   4'hF);
      chk("t1_iip",  IIP,  36'h40);
      for (int i = 1; i < 8; i++) beat(dl + 64'(i), 8'h60);
      IFETCH = 1'b1;
      tick();
      chk("t1_iip1",  IIP,  36'h44);
      chk("t1_ibus1", IBUS, dl + 64'd1);
      tick();
      chk("t1_iip2",  IIP,  36'h48);
      chk("t1_ibus2", IBUS, dl + 64'd2);

      // 2: misaligned target 0x4B, jump coinciding with IFETCH
      STOP = 1'b0;
      jump(36'h4B);
      IFETCH = 1'b0;
      chk("t2_flush", IRDY, 0);
      wait_act(5, n);
      chk("t2_offset", bus.OFFSET, 64'h80);
      STOP = 1'b1;
      wait_drop(12);
      beat(el + 64'd0, 8'h60);
      chk("t2_skip0", IRDY, 0);
      beat(el + 64'd1, 8'h60);
      chk("t2_skip1", IRDY, 0);
      beat(el + 64'd2, 8'h60);
      chk("t2_irdy", IRDY, 1);
      chk("t2_ibus", IBUS, el + 64'd2);
      chk("t2_vf",   VF,   4'b1000);
      chk("t2_iip",  IIP,  36'h48);
      for (int i = 3; i < 8; i++) beat(el + 64'(i), 8'h60);
      IFETCH = 1'b1;
      tick();
      IFETCH = 1'b0;
      chk("t2_iip_next",  IIP,  36'h4C);
      chk("t2_vf_next",   VF,   4'hF);
      chk("t2_ibus_next", IBUS, el + 64'd3);

      // 3: fill the queue with two lines, then no further request
      STOP = 1'b0;
      jump(36'h100);
      wait_act(5, n);
      chk("t3_off1", bus.OFFSET, 64'h200);
      wait_drop(12);
      for (int i = 0; i < 8; i++) beat(l1 + 64'(i), 8'h60);
      wait_act(5, n);
      chk("t3_off2", bus.OFFSET, 64'h240);
      wait_drop(12);
      for (int i = 0; i < 8; i++) beat(l2 + 64'(i), 8'h60);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.ACT) n++;
         tick();
      end
      chk("t3_no_third_act", n, 0);
      chk("t3_irdy", IRDY, 1);
      for (int i = 0; i < 8; i++) begin
         chk("t3_pop_ibus", IBUS, l1 + 64'(i));
         chk("t3_pop_iip",  IIP,  36'h100 + 36'(4 * i));
         IFETCH = 1'b1;
         tick();
      end
      IFETCH = 1'b0;
      chk("t3_head_l2", IBUS, l2);
      wait_act(5, n);
      chk("t3_act_lat", n, 1);
      chk("t3_off3", bus.OFFSET, 64'h280);

      // 4: abandon line after 3 beats; 4th beat coincides with JUMP
      STOP = 1'b1;
      wait_drop(12);
      for (int i = 0; i < 3; i++) beat(pl + 64'(i), 8'h60);
      bus.DRDY = 1'b1; bus.TAGi = 8'h60; bus.DTi = pl + 64'd3;
      STOP = 1'b0;
      jump(36'h200);
      bus.DRDY = 1'b0; bus.TAGi = 8'h00;
      chk("t4_flush", IRDY, 0);
      for (int i = 4; i < 8; i++) begin
         chk("t4_drain_act", bus.ACT, 0);
         beat(pl + 64'(i), 8'h60);
         chk("t4_drain_irdy", IRDY, 0);
      end
      chk("t4_drain_end_act", bus.ACT, 0);
      wait_act(5, n);
      chk("t4_act_lat", n, 1);
      chk("t4_offset", bus.OFFSET, 64'h400);
      STOP = 1'b1;
      wait_drop(12);
      for (int i = 0; i < 8; i++) beat(nl + 64'(i), 8'h60);
      chk("t4_iip", IIP, 36'h200);
      for (int i = 0; i < 8; i++) begin
         chk("t4_pop_ibus", IBUS, nl + 64'(i));
         IFETCH = 1'b1;
         tick();
      end
      IFETCH = 1'b0;
      chk("t4_empty", IRDY, 0);

      // 5: fault beat
      STOP = 1'b0;
      jump(36'h300);
      wait_act(5, n);
      chk("t5_offset", bus.OFFSET, 64'h600);
      wait_drop(12);
      for (int i = 0; i < 8; i++) beat(dl + 64'(i), (i == 1) ? 8'h70 : 8'h60);
`ifdef PF_FAULT_HALT_EN
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.ACT) n++;
         tick();
      end
      chk("t5_halt_no_act", n, 0);
`else
      wait_act(5, n);
      chk("t5_next_lat", n, 1);
      chk("t5_next_off", bus.OFFSET, 64'h640);
      STOP = 1'b1;
`endif
      chk("t5_ierr0", IERR, 0);
      IFETCH = 1'b1;
      tick();
      chk("t5_ierr1", IERR, 1);
      chk("t5_ibus1", IBUS, dl + 64'd1);
      tick();
      IFETCH = 1'b0;
      chk("t5_ierr2", IERR, 0);
`ifndef PF_FAULT_HALT_EN
      wait_drop(12);
      for (int i = 0; i < 8; i++) beat(el + 64'(i), 8'h60);
`endif

      // 6: data timeout
      STOP = 1'b0;
      jump(36'h400);
      wait_act(5, n);
      STOP = 1'b1;
      wait_drop(12);
      for (int i = 0; i < 200; i++) tick();
      chk("t6_fatal_pre", FATAL, 0);
      jump(36'h500);
      for (int i = 0; i < 200; i++) tick();
      chk("t6_fatal_cleared", FATAL, 0);
      n = 0;
      while (!FATAL && n < 100) begin
         tick();
         n++;
      end
      chk("t6_fatal", FATAL, 1);
      chk("t6_fatal_time", n, 56);
      jump(36'h40);
      tick(); tick();
      chk("t6_fatal_sticky", FATAL, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
